// File: rtl/uart_frame_packer_if.sv
// Byte-stream handshake between the frame packer and the UART sender.
// A byte moves on any clock edge where tx_valid and tx_ready are both high.
interface uart_frame_packer_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;

  modport master (
    output tx_valid,
    output tx_data,
    input  tx_ready
  );

  modport slave (
    input  tx_valid,
    input  tx_data,
    output tx_ready
  );
endinterface

// File: rtl/uart_frame_packer.sv
// Snapshots a payload on start and streams sync, type, len, payload,
// CRC-8 and tail bytes over a valid/ready link with backpressure.
module uart_frame_packer #(
  parameter int         PAYLOAD_LEN = 26,
  parameter logic [7:0] SYNC0       = 8'h55,
  parameter logic [7:0] SYNC1       = 8'hBB,
  parameter logic [7:0] TAIL        = 8'hF0,
  parameter logic [7:0] CRC_POLY    = 8'h07,
  parameter logic [7:0] CRC_INIT    = 8'h00
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [7:0]               frame_type,
  input  logic [8*PAYLOAD_LEN-1:0] payload,
  output logic                     busy,
  output logic                     done,
  uart_frame_packer_if.master      tx
);

  localparam int IW = $clog2(PAYLOAD_LEN + 6);
  localparam int PW = 8 * PAYLOAD_LEN;
  localparam logic [7:0]    LEN     = 8'(PAYLOAD_LEN);
  localparam logic [IW-1:0] IDX_TYP = IW'(2);
  localparam logic [IW-1:0] IDX_LEN = IW'(3);
  localparam logic [IW-1:0] IDX_LST = IW'(PAYLOAD_LEN + 3);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_BODY,
    S_CRC,
    S_TAIL
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [7:0]      crc_q, crc_d;
  logic [7:0]      typ_q, typ_d;
  logic [PW-1:0]   pay_q, pay_d;
  logic            vld_q, vld_d;
  logic [7:0]      dat_q, dat_d;
  logic            done_q, done_d;
  logic            xfer;

  function automatic logic [7:0] crc8(
    input logic [7:0] c,
    input logic [7:0] b
  );
    logic [7:0] x;
    x = c ^ b;
    for (int i = 0; i < 8; i++) begin
      x = x[7] ? ((x << 1) ^ CRC_POLY) : (x << 1);
    end
    return x;
  endfunction

  assign xfer = vld_q && tx.tx_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    crc_d   = crc_q;
    typ_d   = typ_q;
    pay_d   = pay_q;
    vld_d   = vld_q;
    dat_d   = dat_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        idx_d = '0;
        if (start) begin
          state_d = S_SYNC;
          crc_d   = CRC_INIT;
          typ_d   = frame_type;
          pay_d   = payload;
          vld_d   = 1'b1;
          dat_d   = SYNC0;
        end
      end
      S_SYNC: begin
        if (xfer) begin
          idx_d = idx_q + 1'b1;
          if (idx_q == '0) begin
            dat_d = SYNC1;
          end else begin
            dat_d   = typ_q;
            state_d = S_BODY;
          end
        end
      end
      S_BODY: begin
        if (xfer) begin
          idx_d = idx_q + 1'b1;
          crc_d = crc8(crc_q, dat_q);
          // payload is consumed from the low byte by shifting the snapshot
          unique case (1'b1)
            (idx_q == IDX_LST): begin
              state_d = S_CRC;
              dat_d   = crc_d;
            end
            (idx_q == IDX_TYP): dat_d = LEN;
            (idx_q == IDX_LEN): dat_d = pay_q[7:0];
            default: begin
              pay_d = pay_q >> 8;
              dat_d = pay_d[7:0];
            end
          endcase
        end
      end
      S_CRC: begin
        if (xfer) begin
          idx_d   = idx_q + 1'b1;
          state_d = S_TAIL;
          dat_d   = TAIL;
        end
      end
      S_TAIL: begin
        if (xfer) begin
          idx_d   = '0;
          state_d = S_IDLE;
          vld_d   = 1'b0;
          dat_d   = 8'h00;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        vld_d   = 1'b0;
        dat_d   = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      crc_q   <= CRC_INIT;
      typ_q   <= 8'h00;
      pay_q   <= '0;
      vld_q   <= 1'b0;
      dat_q   <= 8'h00;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      crc_q   <= crc_d;
      typ_q   <= typ_d;
      pay_q   <= pay_d;
      vld_q   <= vld_d;
      dat_q   <= dat_d;
      done_q  <= done_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign tx.tx_valid = vld_q;
  assign tx.tx_data  = dat_q;

endmodule

// File: tb/tb_uart_frame_packer.sv
// Scoreboard bench for uart_frame_packer: a one-byte instance with
// directed timing checks and a 26-byte instance checked byte by byte.
module tb_uart_frame_packer;

  localparam int P = 26;

  typedef struct packed {
    logic [7:0] b;
    logic       last;
  } exp_t;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           start, start_m;
  logic [7:0]     ftype, ftype_m;
  logic [8*P-1:0] pl;
  logic [7:0]     pl_m;
  logic           busy, done, busy_m, done_m;
  logic           rdy;
  logic           bp_en;

  int   tests = 0;
  int   fails = 0;
  exp_t q[$];
  logic stall = 1'b0;
  logic [7:0] pdat = 8'h00;
  logic exp_done = 1'b0;
  logic [7:0] min_exp [7] = '{8'h55, 8'hBB, 8'h00, 8'h01,
                              8'h00, 8'h15, 8'hF0};

  always #5 clk = ~clk;

  uart_frame_packer_if tx();
  uart_frame_packer_if txm();

  assign tx.tx_ready  = rdy;
  assign txm.tx_ready = 1'b1;

  uart_frame_packer #(.PAYLOAD_LEN(P)) u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .frame_type (ftype),
    .payload    (pl),
    .busy       (busy),
    .done       (done),
    .tx         (tx.master)
  );

  uart_frame_packer #(.PAYLOAD_LEN(1)) u_min (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start_m),
    .frame_type (ftype_m),
    .payload    (pl_m),
    .busy       (busy_m),
    .done       (done_m),
    .tx         (txm.master)
  );

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  // bit-serial reference: feedback = crc msb xor data bit
  function automatic logic [7:0] ref_crc(input logic [7:0] c,
                                         input logic [7:0] b);
    logic fb;
    for (int i = 7; i >= 0; i--) begin
      fb = c[7] ^ b[i];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  function automatic logic [8*P-1:0] mkpl(input logic [7:0] base,
                                          input logic [7:0] step);
    logic [8*P-1:0] r;
    r = '0;
    for (int k = 0; k < P; k++) r[8*k +: 8] = base + step * 8'(k);
    return r;
  endfunction

  task automatic push_frame(input logic [7:0] t, input logic [8*P-1:0] p);
    logic [7:0] c;
    logic [7:0] bt;
    c = 8'h00;
    q.push_back(exp_t'{b: 8'h55, last: 1'b0});
    q.push_back(exp_t'{b: 8'hBB, last: 1'b0});
    q.push_back(exp_t'{b: t, last: 1'b0});
    c = ref_crc(c, t);
    q.push_back(exp_t'{b: 8'(P), last: 1'b0});
    c = ref_crc(c, 8'(P));
    for (int k = 0; k < P; k++) begin
      bt = p[8*k +: 8];
      q.push_back(exp_t'{b: bt, last: 1'b0});
      c = ref_crc(c, bt);
    end
    q.push_back(exp_t'{b: c, last: 1'b0});
    q.push_back(exp_t'{b: 8'hF0, last: 1'b1});
  endtask

  task automatic pulse(input logic [7:0] t, input logic [8*P-1:0] p);
    @(posedge clk); #1;
    ftype = t;
    pl    = p;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("sync0_latency", {tx.tx_valid, busy, tx.tx_data},
          {22'd0, 2'b11, 8'h55});
  endtask

  task automatic wait_done(input int limit);
    for (int n = 0; n < limit; n++) begin
      @(negedge clk);
      if (done) break;
    end
    check("done_timeout", 32'(done), 32'd1);
  endtask

  initial begin
    rdy = 1'b1;
    forever begin
      @(posedge clk); #1;
      rdy = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_done) begin
        check("done_pulse", {done, busy, tx.tx_valid}, 32'b100);
        exp_done = 1'b0;
      end else if (done) begin
        check("spurious_done", 32'(done), 32'd0);
      end
      if (stall && tx.tx_valid) check("stall_hold", tx.tx_data, pdat);
      if (!tx.tx_valid) check("idle_data", tx.tx_data, 32'h0);
      if (tx.tx_valid && rdy) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL extra_byte: got %h, expected no byte", tx.tx_data);
        end else begin
          e = q.pop_front();
          check("frame_byte", tx.tx_data, e.b);
          if (e.last) exp_done = 1'b1;
        end
      end
      stall = tx.tx_valid && !rdy;
      pdat  = tx.tx_data;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    start_m = 1'b0;
    ftype   = 8'h00;
    ftype_m = 8'h00;
    pl      = '0;
    pl_m    = 8'h00;
    bp_en   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {busy, done, tx.tx_valid, tx.tx_data}, 32'h0);
    check("reset_state_min", {busy_m, done_m, txm.tx_valid, txm.tx_data},
          32'h0);
    reset_n = 1'b1;

    // minimal frame, exact cycle timing
    @(posedge clk); #1;
    start_m = 1'b1;
    @(posedge clk); #1;
    start_m = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check("min_byte", {txm.tx_valid, txm.tx_data}, {23'd0, 1'b1, min_exp[i]});
    end
    @(negedge clk);
    check("min_done", {done_m, busy_m, txm.tx_valid}, 32'b100);
    @(negedge clk);
    check("min_done_1cyc", 32'(done_m), 32'd0);

    // default configuration
    push_frame(8'h02, mkpl(8'h00, 8'h01));
    pulse(8'h02, mkpl(8'h00, 8'h01));
    wait_done(100);

    // backpressure
    bp_en = 1'b1;
    push_frame(8'h02, mkpl(8'h00, 8'h01));
    pulse(8'h02, mkpl(8'h00, 8'h01));
    wait_done(400);
    bp_en = 1'b0;

    // snapshot: mid-frame input change and ignored start
    push_frame(8'h11, mkpl(8'h00, 8'h01));
    pulse(8'h11, mkpl(8'h00, 8'h01));
    repeat (10) @(posedge clk);
    #1;
    pl    = mkpl(8'h80, 8'h05);
    ftype = 8'h99;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(100);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no_second_frame", 32'(tx.tx_valid), 32'd0);
    end

    // back-to-back: start in done cycle, CRC must not carry over
    push_frame(8'h22, mkpl(8'h10, 8'h03));
    pulse(8'h22, mkpl(8'h10, 8'h03));
    wait_done(100);
    push_frame(8'h23, mkpl(8'hFF, 8'hF9));
    ftype = 8'h23;
    pl    = mkpl(8'hFF, 8'hF9);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("done_cycle_start", {tx.tx_valid, busy, tx.tx_data},
          {22'd0, 2'b11, 8'h55});
    wait_done(100);

    // reset during payload byte 5 (value A5)
    push_frame(8'h33, mkpl(8'hA0, 8'h01));
    pulse(8'h33, mkpl(8'hA0, 8'h01));
    for (int n = 0; n < 100; n++) begin
      if (tx.tx_valid && tx.tx_data == 8'hA5) break;
      @(negedge clk);
    end
    check("reach_byte5", {tx.tx_valid, tx.tx_data}, {23'd0, 1'b1, 8'hA5});
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset", {tx.tx_valid, busy, done}, 32'h0);
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    push_frame(8'h44, mkpl(8'h3C, 8'h11));
    pulse(8'h44, mkpl(8'h3C, 8'h11));
    wait_done(100);

    @(negedge clk);
    check("queue_empty", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
